// File: rtl/stopwatch_counter.sv
// Centisecond time base plus an MM:SS.cc BCD counter for the stopwatch display.
// init clears everything; en gates the prescaler, so a pause keeps the partial period.
`timescale 1ns/1ps
module stopwatch_counter #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 100,
  parameter bit WRAP    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init,
  input  logic       en,
  output logic [3:0] cs_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] s_ones,
  output logic [3:0] s_tens,
  output logic [3:0] m_ones,
  output logic [3:0] m_tens,
  output logic       tick,
  output logic       overflow
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  generate
    if (DIV < 2 || DIV * TICK_HZ != CLK_HZ) begin : g_bad_div
      $error("stopwatch_counter: CLK_HZ/TICK_HZ must be an integer >= 2");
    end
  endgenerate

  logic [PW-1:0] presc;

  logic [3:0] nxt_cs_ones, nxt_cs_tens, nxt_s_ones, nxt_s_tens, nxt_m_ones, nxt_m_tens;
  logic       c_cs_ones, c_cs_tens, c_s_ones, c_s_tens, c_m_ones;
  logic       terminal;

  // Ripple carry through the six digits; >= keeps the digits inside their ranges.
  always_comb begin
    c_cs_ones   = (cs_ones >= 4'd9);
    nxt_cs_ones = c_cs_ones ? 4'd0 : cs_ones + 4'd1;

    c_cs_tens   = c_cs_ones && (cs_tens >= 4'd9);
    nxt_cs_tens = c_cs_ones ? (c_cs_tens ? 4'd0 : cs_tens + 4'd1) : cs_tens;

    c_s_ones    = c_cs_tens && (s_ones >= 4'd9);
    nxt_s_ones  = c_cs_tens ? (c_s_ones ? 4'd0 : s_ones + 4'd1) : s_ones;

    c_s_tens    = c_s_ones && (s_tens >= 4'd5);
    nxt_s_tens  = c_s_ones ? (c_s_tens ? 4'd0 : s_tens + 4'd1) : s_tens;

    c_m_ones    = c_s_tens && (m_ones >= 4'd9);
    nxt_m_ones  = c_s_tens ? (c_m_ones ? 4'd0 : m_ones + 4'd1) : m_ones;

    terminal    = c_m_ones && (m_tens >= 4'd5);
    nxt_m_tens  = c_m_ones ? (terminal ? 4'd0 : m_tens + 4'd1) : m_tens;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc    <= '0;
      cs_ones  <= 4'd0;
      cs_tens  <= 4'd0;
      s_ones   <= 4'd0;
      s_tens   <= 4'd0;
      m_ones   <= 4'd0;
      m_tens   <= 4'd0;
      tick     <= 1'b0;
      overflow <= 1'b0;
    end else if (init) begin
      presc    <= '0;
      cs_ones  <= 4'd0;
      cs_tens  <= 4'd0;
      s_ones   <= 4'd0;
      s_tens   <= 4'd0;
      m_ones   <= 4'd0;
      m_tens   <= 4'd0;
      tick     <= 1'b0;
      overflow <= 1'b0;
    end else if (en) begin
      if (presc == PRESC_MAX) begin
        presc <= '0;
        tick  <= 1'b1;
        if (terminal) overflow <= 1'b1;
        // Saturating mode keeps 59:59.99 on the terminal advance and all later ones.
        if (!terminal || WRAP) begin
          cs_ones <= nxt_cs_ones;
          cs_tens <= nxt_cs_tens;
          s_ones  <= nxt_s_ones;
          s_tens  <= nxt_s_tens;
          m_ones  <= nxt_m_ones;
          m_tens  <= nxt_m_tens;
        end
      end else begin
        presc <= presc + PW'(1);
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: DIV=10 instance for timing/pause/init/reset cases,
// and a DIV=2 pair (WRAP=1 and WRAP=0) driven in lockstep through the 59:59.99 boundary.
`timescale 1ns/1ps
module tb_stopwatch_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DIV=10 instance
  logic rst_a = 1'b0, init_a = 1'b0, en_a = 1'b0;
  logic [3:0] a_cs1, a_cs10, a_s1, a_s10, a_m1, a_m10;
  logic a_tick, a_ovf;
  logic [23:0] a_time;
  assign a_time = {a_m10, a_m1, a_s10, a_s1, a_cs10, a_cs1};

  // DIV=2 pair sharing stimulus
  logic rst_b = 1'b0, init_b = 1'b0, en_b = 1'b0;
  logic [3:0] w_cs1, w_cs10, w_s1, w_s10, w_m1, w_m10;
  logic w_tick, w_ovf;
  logic [3:0] s_cs1, s_cs10, s_s1, s_s10, s_m1, s_m10;
  logic s_tick, s_ovf;
  logic [23:0] w_time, s_time;
  assign w_time = {w_m10, w_m1, w_s10, w_s1, w_cs10, w_cs1};
  assign s_time = {s_m10, s_m1, s_s10, s_s1, s_cs10, s_cs1};

  stopwatch_counter #(.CLK_HZ(1000), .TICK_HZ(100), .WRAP(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_a), .init(init_a), .en(en_a),
    .cs_ones(a_cs1), .cs_tens(a_cs10), .s_ones(a_s1), .s_tens(a_s10),
    .m_ones(a_m1), .m_tens(a_m10), .tick(a_tick), .overflow(a_ovf)
  );

  stopwatch_counter #(.CLK_HZ(200), .TICK_HZ(100), .WRAP(1'b1)) dut_wrap (
    .clk(clk), .rst_n(rst_b), .init(init_b), .en(en_b),
    .cs_ones(w_cs1), .cs_tens(w_cs10), .s_ones(w_s1), .s_tens(w_s10),
    .m_ones(w_m1), .m_tens(w_m10), .tick(w_tick), .overflow(w_ovf)
  );

  stopwatch_counter #(.CLK_HZ(200), .TICK_HZ(100), .WRAP(1'b0)) dut_sat (
    .clk(clk), .rst_n(rst_b), .init(init_b), .en(en_b),
    .cs_ones(s_cs1), .cs_tens(s_cs10), .s_ones(s_s1), .s_tens(s_s10),
    .m_ones(s_m1), .m_tens(s_m10), .tick(s_tick), .overflow(s_ovf)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected BCD display for a count of centiseconds, derived arithmetically.
  function automatic logic [23:0] bcd_of(input int cs);
    bcd_of = {4'(cs / 60000), 4'((cs / 6000) % 10), 4'((cs / 1000) % 6),
              4'((cs / 100) % 10), 4'((cs / 10) % 10), 4'(cs % 10)};
  endfunction

  typedef struct {
    bit init;
    bit en;
    int n;          // cycles to apply
    int ticks;      // ticks expected during those cycles
    bit last_tick;  // tick value after the final cycle
    int cs;         // expected time after the final cycle
    bit ovf;
  } vec_t;

  vec_t vecs[$];
  int   model_a = 0;

  // Waits for the next tick of dut_a and returns the cycle gap.
  task automatic wait_tick_a(output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!a_tick && gap < 20);
  endtask

  task automatic run_to_a(input int target);
    int gap;
    while (model_a < target) begin
      wait_tick_a(gap);
      check($sformatf("period_at_cs%0d", model_a + 1), gap, 10);
      if (!a_tick) return;
      model_a++;
      check($sformatf("time_at_cs%0d", model_a), a_time, bcd_of(model_a));
    end
  endtask

  task automatic thread_a();
    int nt;
    bit lt;
    int gap;
    repeat (2) @(negedge clk);
    check("a_reset_time", a_time, 24'h0);
    check("a_reset_tick", a_tick, 0);
    check("a_reset_ovf", a_ovf, 0);
    rst_a = 1'b1;
    @(negedge clk);

    // Tick timing, pause, and mid-period init
    foreach (vecs[k]) begin
      init_a = vecs[k].init;
      en_a   = vecs[k].en;
      nt = 0;
      lt = 1'b0;
      for (int i = 0; i < vecs[k].n; i++) begin
        @(negedge clk);
        init_a = 1'b0;
        lt = a_tick;
        if (a_tick) nt++;
      end
      check($sformatf("vec%0d_ticks", k), nt, vecs[k].ticks);
      check($sformatf("vec%0d_last_tick", k), lt, vecs[k].last_tick);
      check($sformatf("vec%0d_time", k), a_time, bcd_of(vecs[k].cs));
      check($sformatf("vec%0d_ovf", k), a_ovf, vecs[k].ovf);
    end

    // Carry chain: every tick checked up to 03:21.57
    init_a = 1'b1;
    en_a   = 1'b1;
    @(negedge clk);
    init_a  = 1'b0;
    model_a = 0;
    run_to_a(99);
    run_to_a(100);
    check("a_time_00_01_00", a_time, 24'h000100);
    run_to_a(5999);
    run_to_a(6000);
    check("a_time_01_00_00", a_time, 24'h010000);
    run_to_a(20157);
    check("a_time_03_21_57", a_time, 24'h032157);

    // Asynchronous reset between edges, then count without init
    rst_a = 1'b0;
    #1;
    check("a_async_rst_time", a_time, 24'h0);
    check("a_async_rst_tick", a_tick, 0);
    check("a_async_rst_ovf", a_ovf, 0);
    @(negedge clk);
    rst_a = 1'b1;
    wait_tick_a(gap);
    check("a_post_rst_gap", gap, 10);
    check("a_post_rst_time", a_time, 24'h000001);
  endtask

  task automatic thread_b();
    int cyc;
    int gap;
    repeat (2) @(negedge clk);
    check("w_reset_time", w_time, 24'h0);
    check("s_reset_ovf", s_ovf, 0);
    rst_b = 1'b1;
    @(negedge clk);
    init_b = 1'b1;
    en_b   = 1'b1;
    @(negedge clk);
    init_b = 1'b0;

    cyc = 0;
    while (!(w_tick && w_time == 24'h595999) && cyc < 800000) begin
      @(negedge clk);
      cyc++;
    end
    check("w_reach_59_59_99", w_time, 24'h595999);
    check("w_cycles_to_max", cyc, 2 * 359999);
    check("s_at_max_time", s_time, 24'h595999);
    check("w_at_max_ovf", w_ovf, 0);
    check("s_at_max_ovf", s_ovf, 0);

    // Terminal advance
    gap = 0;
    do begin @(negedge clk); gap++; end while (!w_tick && gap < 8);
    check("term_gap", gap, 2);
    check("w_term_time", w_time, 24'h000000);
    check("w_term_ovf", w_ovf, 1);
    check("s_term_time", s_time, 24'h595999);
    check("s_term_ovf", s_ovf, 1);
    check("s_term_tick", s_tick, 1);

    for (int k = 1; k <= 3; k++) begin
      gap = 0;
      do begin @(negedge clk); gap++; end while (!w_tick && gap < 8);
      check($sformatf("w_after_term%0d_time", k), w_time, bcd_of(k));
      check($sformatf("w_after_term%0d_ovf", k), w_ovf, 1);
      check($sformatf("s_after_term%0d_time", k), s_time, 24'h595999);
      check($sformatf("s_after_term%0d_tick", k), s_tick, 1);
      check($sformatf("s_after_term%0d_ovf", k), s_ovf, 1);
    end

    // Sticky overflow only cleared by init
    en_b = 1'b0;
    repeat (3) @(negedge clk);
    check("w_ovf_held_paused", w_ovf, 1);
    init_b = 1'b1;
    @(negedge clk);
    init_b = 1'b0;
    check("w_ovf_after_init", w_ovf, 0);
    check("s_ovf_after_init", s_ovf, 0);
    check("s_time_after_init", s_time, 24'h0);
  endtask

  initial begin
    // Tick timing: init+en, then 25 enabled cycles
    vecs.push_back('{1, 1, 1,     0,    0, 0,    0});
    vecs.push_back('{0, 1, 10,    1,    1, 1,    0});
    vecs.push_back('{0, 1, 10,    1,    1, 2,    0});
    vecs.push_back('{0, 1, 5,     0,    0, 2,    0});
    // Pause keeps the partial period
    vecs.push_back('{1, 1, 1,     0,    0, 0,    0});
    vecs.push_back('{0, 1, 7,     0,    0, 0,    0});
    vecs.push_back('{0, 0, 50,    0,    0, 0,    0});
    vecs.push_back('{0, 1, 3,     1,    1, 1,    0});
    // init at 00:12.34 mid-period
    vecs.push_back('{1, 1, 1,     0,    0, 0,    0});
    vecs.push_back('{0, 1, 12340, 1234, 1, 1234, 0});
    vecs.push_back('{0, 1, 5,     0,    0, 1234, 0});
    vecs.push_back('{1, 1, 1,     0,    0, 0,    0});
    vecs.push_back('{0, 1, 9,     0,    0, 0,    0});
    vecs.push_back('{0, 1, 1,     1,    1, 1,    0});

    fork
      thread_a();
      thread_b();
    join

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
